mod100_bcd_split: RTL and testbench

MOD100_BCD_SPLIT -- requirements
Module: mod100_bcd_split

---
 rtl/mod100_bcd_split_pkg.sv | 22 ++
 rtl/mod100_bcd_split.sv | 116 +++++++++++
 tb/tb_mod100_bcd_split.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mod100_bcd_split_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mod100_bcd_split_pkg
// Brief    : Shared FSM state, BCD digit type and constants for the splitter.
// Revision : 1.0
// ============================================================================
package mod100_bcd_split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_VAL = 99;
    localparam int RADIX   = 10;

endpackage
`default_nettype wire

// File: rtl/mod100_bcd_split.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mod100_bcd_split
// Brief    : Binary 0..MAX_VAL to two BCD digits by repeated subtract-10.
// Revision : 1.0
// ============================================================================
module mod100_bcd_split
    import mod100_bcd_split_pkg::*;
#(
    parameter int IN_W    = 7,
    parameter int MAX_VAL = mod100_bcd_split_pkg::MAX_VAL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [3:0]      out_tens,
    output logic [3:0]      out_ones,
    output logic            out_err,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [IN_W-1:0] c_RADIX     = IN_W'(RADIX);
    localparam logic [IN_W-1:0] c_DIGIT_REM = IN_W'(RADIX - 1);
    localparam bcd_t            c_DIGIT_MAX = bcd_t'(RADIX - 1);

    state_t          r_state_q;
    state_t          w_state_d;
    logic [IN_W-1:0] r_rem_q;
    logic [IN_W-1:0] w_rem_d;
    bcd_t            r_tens_q;
    bcd_t            w_tens_d;
    logic            r_err_q;
    logic            w_err_d;
    logic            r_run_q;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_over;

    // r_run_q keeps in_ready low until the first edge after reset release.
    assign w_in_ready  = (r_state_q == IDLE) && r_run_q && rst;
    assign w_out_valid = (r_state_q == HOLD) && rst;
    assign w_accept    = w_in_ready && in_valid;
    assign w_over      = (int'(in_data) > MAX_VAL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= IDLE;
            r_rem_q   <= '0;
            r_tens_q  <= '0;
            r_err_q   <= 1'b0;
            r_run_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_rem_q   <= w_rem_d;
            r_tens_q  <= w_tens_d;
            r_err_q   <= w_err_d;
            r_run_q   <= 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_rem_d   = r_rem_q;
        w_tens_d  = r_tens_q;
        w_err_d   = r_err_q;
        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_over) begin
                        // Out-of-range input skips division and reports 99 with err.
                        w_err_d   = 1'b1;
                        w_tens_d  = c_DIGIT_MAX;
                        w_rem_d   = c_DIGIT_REM;
                        w_state_d = HOLD;
                    end else begin
                        w_err_d   = 1'b0;
                        w_tens_d  = '0;
                        w_rem_d   = in_data;
                        w_state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (r_rem_q >= c_RADIX) begin
                    w_rem_d  = r_rem_q - c_RADIX;
                    w_tens_d = r_tens_q + bcd_t'(1);
                end else begin
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Digits are only presented while the result is valid.
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_tens  = w_out_valid ? r_tens_q     : 4'd0;
    assign out_ones  = w_out_valid ? r_rem_q[3:0] : 4'd0;
    assign out_err   = w_out_valid && r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod100_bcd_split.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mod100_bcd_split
// Brief    : Self-checking bench for mod100_bcd_split.
// Revision : 1.0
// ============================================================================
module tb_mod100_bcd_split;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_tens;
    logic [3:0] out_ones;
    logic       out_err;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;

    typedef struct {
        int din;
        int hold;
        int tens;
        int ones;
        int err;
        int lat;
    } vec_t;

    vec_t vecs[8];

    mod100_bcd_split #(
        .IN_W    (7),
        .MAX_VAL (99)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_tens  (out_tens),
        .out_ones  (out_ones),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) xfer_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: decimal split by division, saturate to 99 with err when above range.
    function automatic void ref_model(input int v, output int t, output int o,
                                      output int e, output int lat);
        if (v > 99) begin
            t = 9; o = 9; e = 1; lat = 1;
        end else begin
            t = v / 10; o = v % 10; e = 0; lat = v / 10 + 2;
        end
    endfunction

    task automatic run_txn(input int din, input int hold, input int et, input int eo,
                           input int ee, input int elat);
        int lat;
        int x0;
        int w;
        @(negedge clk);
        out_ready = (hold == 0);
        in_data   = 7'(din);
        in_valid  = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", int'(in_ready), 1);
        x0 = xfer_cnt;
        // Keep in_valid high with junk data to show it is ignored past the accept.
        @(negedge clk);
        in_data = 7'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("busy_in_ready", int'(in_ready), 0);
            @(negedge clk);
            in_data = 7'($urandom);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, elat);
        check("tens", int'(out_tens), et);
        check("ones", int'(out_ones), eo);
        check("err", int'(out_err), ee);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_tens", int'(out_tens), et);
            check("hold_ones", int'(out_ones), eo);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("exit_valid", int'(out_valid), 0);
        check("exit_in_ready", int'(in_ready), 1);
        check("single_xfer", xfer_cnt - x0, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int seq[4];
        int t, o, e, l;
        int acc, got, saw_valid, x0;

        vecs[0] = '{0,   0, 0, 0, 0, 2};
        vecs[1] = '{99,  0, 9, 9, 0, 11};
        vecs[2] = '{120, 0, 9, 9, 1, 1};
        vecs[3] = '{47,  5, 4, 7, 0, 6};
        vecs[4] = '{10,  1, 1, 0, 0, 3};
        vecs[5] = '{9,   0, 0, 9, 0, 2};
        vecs[6] = '{100, 2, 9, 9, 1, 1};
        vecs[7] = '{127, 0, 9, 9, 1, 1};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_tens", int'(out_tens), 0);
        check("rst_ones", int'(out_ones), 0);
        check("rst_err", int'(out_err), 0);
        rst = 1'b1;
        #1;
        check("release_in_ready_pre_edge", int'(in_ready), 0);
        @(negedge clk);
        check("release_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].din, vecs[i].hold, vecs[i].tens, vecs[i].ones,
                    vecs[i].err, vecs[i].lat);
        end

        for (int i = 0; i < 20; i++) begin
            int v;
            v = int'($urandom_range(0, 127));
            ref_model(v, t, o, e, l);
            run_txn(v, int'($urandom_range(0, 2)), t, o, e, l);
        end

        // Reset in the third DIV cycle of an 85 conversion aborts it.
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = 7'd85;
        in_valid  = 1'b1;
        x0 = xfer_cnt;
        saw_valid = 0;
        check("abort_accept_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (out_valid) saw_valid = 1;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
            check("abort_rst_in_ready", int'(in_ready), 0);
        end
        rst = 1'b1;
        #1;
        check("abort_release_in_ready_pre_edge", int'(in_ready), 0);
        @(negedge clk);
        check("abort_release_in_ready", int'(in_ready), 1);
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        check("abort_no_valid", saw_valid, 0);
        check("abort_no_xfer", xfer_cnt - x0, 0);

        // Streamed mod-100 count with in_valid held high.
        seq[0] = 98; seq[1] = 99; seq[2] = 0; seq[3] = 1;
        acc = 0;
        got = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = 7'(seq[0]);
        in_valid  = 1'b1;
        for (int c = 0; c < 200 && got < 4; c++) begin
            if (in_ready && in_valid) acc++;
            @(negedge clk);
            if (acc < 4) in_data = 7'(seq[acc]);
            else         in_valid = 1'b0;
            if (out_valid) begin
                ref_model(seq[got], t, o, e, l);
                check("stream_tens", int'(out_tens), t);
                check("stream_ones", int'(out_ones), o);
                check("stream_err", int'(out_err), e);
                got++;
            end
        end
        in_valid = 1'b0;
        check("stream_accepts", acc, 4);
        check("stream_outputs", got, 4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
